// File: rtl/uart_receiver.sv
// 8N1 UART receive core: synchronises rx, detects a start edge, samples mid-bit
// at a programmable divisor and emits one byte per frame with a one-cycle strobe.
module uart_receiver #(
    parameter int DIVISION_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIVISION_WIDTH-1:0] division,
    input  logic                      rx,
    output logic [7:0]                data,
    output logic                      valid,
    output logic                      frame_error,
    output logic                      busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [DIVISION_WIDTH-1:0] DIV_MIN = DIVISION_WIDTH'(2);
    localparam logic [DIVISION_WIDTH-1:0] DIV_ONE = DIVISION_WIDTH'(1);

    logic                      rx_meta;
    logic                      rx_sync;
    logic                      rx_prev;
    logic [1:0]                state;
    logic [DIVISION_WIDTH-1:0] div_eff;
    logic [DIVISION_WIDTH-1:0] div_q;
    logic [DIVISION_WIDTH-1:0] bit_cnt;
    logic [2:0]                bit_idx;
    logic [7:0]                shift_reg;
    logic                      tick;
    logic                      start_edge;

    // Output protocol: valid and frame_error are single-cycle strobes with no
    // ready/back-pressure; the consumer must capture data in the strobe cycle.

    assign div_eff    = (division < DIV_MIN) ? DIV_MIN : division;
    assign tick       = (bit_cnt == '0);
    assign start_edge = rx_prev & ~rx_sync;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div_q       <= '0;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_error <= 1'b0;
            if (state != IDLE) begin
                bit_cnt <= tick ? (div_q - DIV_ONE) : (bit_cnt - DIV_ONE);
            end
            case (state)
                IDLE: begin
                    // Edge-triggered start: a held-low break cannot re-arm the receiver.
                    if (start_edge) begin
                        div_q   <= div_eff;
                        bit_cnt <= (div_eff >> 1) - DIV_ONE;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_sync) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_sync) begin
                            data  <= shift_reg;
                            valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
